seg_display_arbiter: RTL and testbench

Shares the 4-digit 7-segment display between two requesters, e.g. a switch-status source and a PS/2 scancode source. It sits in front of `mercury_8seg` and drives its `A_TO_G0_in`..`A_TO_G3_in` and `DOTS_in`. Each requester presents a 16-bit hex value plus dots and a request. The arbiter grants ownership round-robin, latches and hex-encodes the value, and holds it on the display for a minimum dwell time before another capture is allowed.

---
 rtl/seg_display_arbiter.sv | 156 +++++++++++++++
 tb/tb_seg_display_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing a 4-digit 7-segment display between two requesters,
// with a minimum dwell after each capture. Optional macro: SEG_ARB_BLANK_LEAD_EN.
module seg_display_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 26
) (
  input  logic        app_clk,
  input  logic        app_arst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [3:0]  dots0,
  input  logic [3:0]  dots1,
  output logic        ack0,
  output logic        ack1,
  output logic [6:0]  A_TO_G0_out,
  output logic [6:0]  A_TO_G1_out,
  output logic [6:0]  A_TO_G2_out,
  output logic [6:0]  A_TO_G3_out,
  output logic [3:0]  DOTS_out,
  output logic        owner,
  output logic        owner_vld
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_OPEN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1111110;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1101101;
      4'h3: seg = 7'b1111001;
      4'h4: seg = 7'b0110011;
      4'h5: seg = 7'b1011011;
      4'h6: seg = 7'b1011111;
      4'h7: seg = 7'b1110000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111011;
      4'hA: seg = 7'b1110111;
      4'hB: seg = 7'b0011111;
      4'hC: seg = 7'b1001110;
      4'hD: seg = 7'b0111101;
      4'hE: seg = 7'b1001111;
      default: seg = 7'b1000111;
    endcase
    return seg;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             cap, cap_idx;
  logic             owner_req, other_req;
  logic [15:0]      cap_val;
  logic [3:0]       cap_dots;
  logic [3:0]       blank;
  logic [3:0][6:0]  seg_nxt, seg_q;

  assign owner_req = owner ? req1 : req0;
  assign other_req = owner ? req0 : req1;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    cap_idx   = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0) begin
          cap     = 1'b1;
          cap_idx = 1'b0;
        end else if (req1) begin
          cap     = 1'b1;
          cap_idx = 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == '0) state_nxt = S_OPEN;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      S_OPEN: begin
        // The non-owner is served first so a busy owner cannot starve the other side.
        if (other_req) begin
          cap     = 1'b1;
          cap_idx = ~owner;
        end else if (owner_req) begin
          cap     = 1'b1;
          cap_idx = owner;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (cap) begin
      state_nxt = S_HOLD;
      cnt_nxt   = HOLD_LOAD;
    end
  end

  assign cap_val  = cap_idx ? val1  : val0;
  assign cap_dots = cap_idx ? dots1 : dots0;

`ifdef SEG_ARB_BLANK_LEAD_EN
  // Blanking runs from digit 3 down and stops at the first nonzero nibble; digit 0 always shows.
  assign blank[3] = (cap_val[15:12] == 4'h0);
  assign blank[2] = blank[3] && (cap_val[11:8] == 4'h0);
  assign blank[1] = blank[2] && (cap_val[7:4]  == 4'h0);
  assign blank[0] = 1'b0;
`else
  assign blank = 4'b0000;
`endif

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      seg_nxt[i] = blank[i] ? 7'b0000000 : hex_to_seg(cap_val[4*i +: 4]);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge app_clk or negedge app_arst_n) begin
    if (!app_arst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      seg_q     <= '0;
      DOTS_out  <= 4'b0000;
      owner     <= 1'b0;
      owner_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ack0  <= cap && !cap_idx;
      ack1  <= cap &&  cap_idx;
      if (cap) begin
        seg_q     <= seg_nxt;
        DOTS_out  <= cap_dots;
        owner     <= cap_idx;
        owner_vld <= 1'b1;
      end
    end
  end

  assign A_TO_G0_out = seg_q[0];
  assign A_TO_G1_out = seg_q[1];
  assign A_TO_G2_out = seg_q[2];
  assign A_TO_G3_out = seg_q[3];

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter: directed sequences plus a capture vector table.
module tb_seg_display_arbiter;

  localparam int unsigned HOLD = 4;

  logic        app_clk = 1'b0;
  logic        app_arst_n;
  logic        req0, req1;
  logic [15:0] val0, val1;
  logic [3:0]  dots0, dots1;
  logic        ack0, ack1;
  logic [6:0]  seg0, seg1, seg2, seg3;
  logic [3:0]  dots_out;
  logic        owner, owner_vld;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 app_clk = ~app_clk;

  seg_display_arbiter #(.HOLD_CYCLES(HOLD), .CNT_W(26)) dut (
    .app_clk    (app_clk),
    .app_arst_n (app_arst_n),
    .req0       (req0),
    .req1       (req1),
    .val0       (val0),
    .val1       (val1),
    .dots0      (dots0),
    .dots1      (dots1),
    .ack0       (ack0),
    .ack1       (ack1),
    .A_TO_G0_out(seg0),
    .A_TO_G1_out(seg1),
    .A_TO_G2_out(seg2),
    .A_TO_G3_out(seg3),
    .DOTS_out   (dots_out),
    .owner      (owner),
    .owner_vld  (owner_vld)
  );

  typedef struct {
    logic        r0, r1;
    logic [15:0] v0, v1;
    logic [3:0]  d0, d1;
    logic        a0, a1;
    logic [27:0] seg;
    logic [3:0]  dots;
    logic        own;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge app_clk);
  endtask

  function automatic logic [27:0] segs();
    return {seg3, seg2, seg1, seg0};
  endfunction

  initial begin
    // Captures in order; expected owner/round-robin results follow from the previous row.
    vecs[0] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 4'b0001, 4'b0000, 1'b1, 1'b0,
                {7'h30, 7'h6D, 7'h79, 7'h33}, 4'b0001, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h5678, 16'h9ABC, 4'b0000, 4'b1010, 1'b0, 1'b1,
                {7'h7B, 7'h77, 7'h1F, 7'h4E}, 4'b1010, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 16'hDEF0, 16'h1111, 4'b0100, 4'b0000, 1'b1, 1'b0,
                {7'h3D, 7'h4F, 7'h47, 7'h7E}, 4'b0100, 1'b0};
`ifdef SEG_ARB_BLANK_LEAD_EN
    vecs[3] = '{1'b1, 1'b0, 16'h0070, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0,
                {7'h00, 7'h00, 7'h70, 7'h7E}, 4'b0000, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 4'b0000, 4'b1111, 1'b0, 1'b1,
                {7'h00, 7'h00, 7'h00, 7'h7E}, 4'b1111, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 4'b1000, 4'b0000, 1'b1, 1'b0,
                {7'h00, 7'h00, 7'h00, 7'h5B}, 4'b1000, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'h0800, 4'b0000, 4'b0000, 1'b0, 1'b1,
                {7'h00, 7'h7F, 7'h7E, 7'h7E}, 4'b0000, 1'b1};
`else
    vecs[3] = '{1'b1, 1'b0, 16'h0070, 16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b0,
                {7'h7E, 7'h7E, 7'h70, 7'h7E}, 4'b0000, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 4'b0000, 4'b1111, 1'b0, 1'b1,
                {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b1111, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 4'b1000, 4'b0000, 1'b1, 1'b0,
                {7'h7E, 7'h7E, 7'h7E, 7'h5B}, 4'b1000, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 16'h0000, 16'h0800, 4'b0000, 4'b0000, 1'b0, 1'b1,
                {7'h7E, 7'h7F, 7'h7E, 7'h7E}, 4'b0000, 1'b1};
`endif
    vecs[5] = '{1'b0, 1'b1, 16'h0000, 16'hBEEF, 4'b0000, 4'b0011, 1'b0, 1'b1,
                {7'h1F, 7'h4F, 7'h4F, 7'h47}, 4'b0011, 1'b1};

    app_arst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    val0 = '0;   val1 = '0;
    dots0 = '0;  dots1 = '0;

    // Reset state
    step(2);
    check("rst_segs", 32'(segs()), 32'h0);
    check("rst_misc", {ack0, ack1, dots_out, owner, owner_vld}, 32'h0);
    app_arst_n = 1'b1;
    step(1);
    check("idle_no_req", {ack0, ack1, owner_vld}, 32'h0);

    // Simultaneous requests from IDLE: req0 wins; also the first-capture image
    req0 = 1'b1; req1 = 1'b1;
    val0 = 16'h1234; dots0 = 4'b0001;
    val1 = 16'hFFFF; dots1 = 4'b0110;
    step(1);
    check("sim_ack", {ack0, ack1}, 32'b10);
    check("first_segs", 32'(segs()), {4'h0, 7'h30, 7'h6D, 7'h79, 7'h33});
    check("first_misc", {dots_out, owner, owner_vld}, {26'h0, 4'b0001, 1'b0, 1'b1});

    // Dwell and round-robin with both requests held
    for (int i = 1; i <= 5; i++) begin
      step(1);
      check($sformatf("rr1_c%0d", i), {ack0, ack1}, (i == 5) ? 32'b01 : 32'b00);
    end
    check("rr1_owner", {owner, dots_out}, {27'h0, 1'b1, 4'b0110});
    check("rr1_segs", 32'(segs()), {4'h0, 7'h47, 7'h47, 7'h47, 7'h47});
    for (int i = 1; i <= 5; i++) begin
      step(1);
      check($sformatf("rr2_c%0d", i), {ack0, ack1}, (i == 5) ? 32'b10 : 32'b00);
    end
    check("rr2_owner", {31'h0, owner}, 32'h0);

    // Retention: no requests for 100 cycles
    req0 = 1'b0; req1 = 1'b0;
    begin
      int bad_cycles;
      bad_cycles = 0;
      for (int i = 0; i < 100; i++) begin
        step(1);
        if (ack0 || ack1 || segs() != {7'h30, 7'h6D, 7'h79, 7'h33} ||
            dots_out != 4'b0001 || owner != 1'b0 || owner_vld != 1'b1)
          bad_cycles++;
      end
      check("retain_cycles_bad", 32'(bad_cycles), 32'h0);
    end
    req0 = 1'b1; val0 = 16'hBEEF; dots0 = 4'b0000;
    step(1);
    check("beef_ack", {ack0, ack1}, 32'b10);
    check("beef_segs", 32'(segs()), {4'h0, 7'h1F, 7'h4F, 7'h4F, 7'h47});
    step(1);
    check("own_no_recap", {ack0, ack1}, 32'b00);
    req0 = 1'b0;

    // Table of single captures, each started from OPEN
    for (int v = 0; v < 8; v++) begin
      step(HOLD + 2);
      req0 = vecs[v].r0; req1 = vecs[v].r1;
      val0 = vecs[v].v0; val1 = vecs[v].v1;
      dots0 = vecs[v].d0; dots1 = vecs[v].d1;
      step(1);
      check($sformatf("vec%0d_ack", v), {ack0, ack1}, {30'h0, vecs[v].a0, vecs[v].a1});
      check($sformatf("vec%0d_segs", v), 32'(segs()), 32'(vecs[v].seg));
      check($sformatf("vec%0d_misc", v), {dots_out, owner, owner_vld},
            {26'h0, vecs[v].dots, vecs[v].own, 1'b1});
      req0 = 1'b0; req1 = 1'b0;
    end

    // Reset mid-HOLD, then pending req1 captured right after release
    step(HOLD + 2);
    req0 = 1'b1; val0 = 16'h4321; dots0 = 4'b1001;
    step(1);
    check("mh_ack", {ack0, ack1}, 32'b10);
    req0 = 1'b0; req1 = 1'b1; val1 = 16'hA5C3; dots1 = 4'b0101;
    step(1);
    #2;
    app_arst_n = 1'b0;
    #1;
    check("mh_rst_segs", 32'(segs()), 32'h0);
    check("mh_rst_misc", {ack0, ack1, dots_out, owner, owner_vld}, 32'h0);
    step(1);
    app_arst_n = 1'b1;
    step(1);
    check("mh_rel_ack", {ack0, ack1}, 32'b01);
    check("mh_rel_segs", 32'(segs()), {4'h0, 7'h77, 7'h5B, 7'h4E, 7'h79});
    check("mh_rel_misc", {dots_out, owner, owner_vld}, {26'h0, 4'b0101, 1'b1, 1'b1});
    req1 = 1'b0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
